// File: rtl/dma_mm2s_engine_if.sv
// AXI3 read-address/read-data channels plus the accelerator stream, bundled
// so the DMA engine and its memory/sink counterpart share one port.
interface dma_mm2s_engine_if #(
  parameter int DATA_W = 64
);
  logic [2:0]        m_axi_acp_arid;
  logic [31:0]       m_axi_acp_araddr;
  logic [3:0]        m_axi_acp_arlen;
  logic [2:0]        m_axi_acp_arsize;
  logic [1:0]        m_axi_acp_arburst;
  logic [3:0]        m_axi_acp_arcache;
  logic [2:0]        m_axi_acp_arprot;
  logic              m_axi_acp_arvalid;
  logic              m_axi_acp_arready;
  logic [DATA_W-1:0] m_axi_acp_rdata;
  logic [1:0]        m_axi_acp_rresp;
  logic              m_axi_acp_rlast;
  logic              m_axi_acp_rvalid;
  logic              m_axi_acp_rready;
  logic [DATA_W-1:0] mm2s_data;
  logic              mm2s_valid;
  logic              mm2s_last;
  logic              mm2s_ready;

  // The engine side: drives AR and the stream, consumes R and downstream ready.
  modport master (
    output m_axi_acp_arid, m_axi_acp_araddr, m_axi_acp_arlen, m_axi_acp_arsize,
           m_axi_acp_arburst, m_axi_acp_arcache, m_axi_acp_arprot, m_axi_acp_arvalid,
           m_axi_acp_rready, mm2s_data, mm2s_valid, mm2s_last,
    input  m_axi_acp_arready, m_axi_acp_rdata, m_axi_acp_rresp, m_axi_acp_rlast,
           m_axi_acp_rvalid, mm2s_ready
  );

  modport slave (
    input  m_axi_acp_arid, m_axi_acp_araddr, m_axi_acp_arlen, m_axi_acp_arsize,
           m_axi_acp_arburst, m_axi_acp_arcache, m_axi_acp_arprot, m_axi_acp_arvalid,
           m_axi_acp_rready, mm2s_data, mm2s_valid, mm2s_last,
    output m_axi_acp_arready, m_axi_acp_rdata, m_axi_acp_rresp, m_axi_acp_rlast,
           m_axi_acp_rvalid, mm2s_ready
  );
endinterface

// File: rtl/dma_mm2s_engine.sv
// AXI3 read DMA: splits a beat count into 4 KB-safe INCR bursts, keeps several
// in flight, and passes the returned data straight through to a stream.
module dma_mm2s_engine #(
  parameter int         DATA_W          = 64,
  parameter int         BURST_LEN       = 16,
  parameter int         MAX_OUTSTANDING = 4,
  parameter int         LEN_W           = 24,
  parameter logic [2:0] AXI_ID          = 3'b100
) (
  input  logic             m_axi_acp_aclk,
  input  logic             axi_reset,
  input  logic             start,
  input  logic [31:0]      src_address,
  input  logic [LEN_W-1:0] xfer_beats,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       last_resp,
  dma_mm2s_engine_if.master bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] remIssue_q, remIssue_d;
  logic [LEN_W-1:0] total_q, total_d;
  logic [LEN_W-1:0] rcvd_q, rcvd_d;
  logic [3:0]       outst_q, outst_d;
  logic             arValid_q, arValid_d;
  logic [31:0]      arAddr_q, arAddr_d;
  logic [3:0]       arLen_q, arLen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       lastResp_q, lastResp_d;

  logic             arHs;
  logic             rHs;
  logic [12:0]      toBoundary;
  logic [4:0]       burstBeats;
  logic [4:0]       issuedBeats;

  assign arHs        = arValid_q & bus.m_axi_acp_arready;
  assign rHs         = bus.m_axi_acp_rvalid & bus.m_axi_acp_rready;
  assign issuedBeats = {1'b0, arLen_q} + 5'd1;

  // Next burst size: capped by the burst limit, what is left, and the 4 KB page end.
  always_comb begin
    toBoundary = (13'h1000 - {1'b0, addr_q[11:0]}) >> SIZE;
    burstBeats = 5'(BURST_LEN);
    if (remIssue_q < LEN_W'(burstBeats)) begin
      burstBeats = 5'(remIssue_q);
    end
    if (toBoundary < 13'(burstBeats)) begin
      burstBeats = 5'(toBoundary);
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remIssue_d = remIssue_q;
    total_d    = total_q;
    rcvd_d     = rcvd_q;
    outst_d    = outst_q;
    arValid_d  = arValid_q;
    arAddr_d   = arAddr_q;
    arLen_d    = arLen_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    lastResp_d = lastResp_q;

    if (rHs) begin
      rcvd_d = rcvd_q + LEN_W'(1);
      if (bus.m_axi_acp_rresp != 2'b00) begin
        error_d = 1'b1;
        if (!error_q) begin
          lastResp_d = bus.m_axi_acp_rresp;
        end
      end
    end

    unique case ({arHs, rHs & bus.m_axi_acp_rlast})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = (outst_q != 4'd0) ? outst_q - 4'd1 : outst_q;
      default: outst_d = outst_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d     = src_address & ~32'(BYTES - 1);
          remIssue_d = xfer_beats;
          total_d    = xfer_beats;
          rcvd_d     = '0;
          error_d    = 1'b0;
          lastResp_d = 2'b00;
          busy_d     = 1'b1;
          // An empty transfer shows busy and done together for its single cycle.
          if (xfer_beats == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!arValid_q) begin
          if ((outst_q < 4'(MAX_OUTSTANDING)) && (remIssue_q != '0)) begin
            arValid_d = 1'b1;
            arAddr_d  = addr_q;
            arLen_d   = 4'(burstBeats - 5'd1);
          end
        end else if (bus.m_axi_acp_arready) begin
          arValid_d  = 1'b0;
          addr_d     = addr_q + (32'(issuedBeats) << SIZE);
          remIssue_d = remIssue_q - LEN_W'(issuedBeats);
          if (remIssue_q == LEN_W'(issuedBeats)) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (rcvd_d == total_q) begin
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_acp_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remIssue_q <= '0;
      total_q    <= '0;
      rcvd_q     <= '0;
      outst_q    <= '0;
      arValid_q  <= 1'b0;
      arAddr_q   <= '0;
      arLen_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      lastResp_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remIssue_q <= remIssue_d;
      total_q    <= total_d;
      rcvd_q     <= rcvd_d;
      outst_q    <= outst_d;
      arValid_q  <= arValid_d;
      arAddr_q   <= arAddr_d;
      arLen_q    <= arLen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      lastResp_q <= lastResp_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign last_resp = lastResp_q;

  assign bus.m_axi_acp_arid    = AXI_ID;
  assign bus.m_axi_acp_araddr  = arAddr_q;
  assign bus.m_axi_acp_arlen   = arLen_q;
  assign bus.m_axi_acp_arsize  = 3'(SIZE);
  assign bus.m_axi_acp_arburst = 2'b01;
  assign bus.m_axi_acp_arcache = 4'b0011;
  assign bus.m_axi_acp_arprot  = 3'b010;
  assign bus.m_axi_acp_arvalid = arValid_q;

  // No buffering: the stream is a gated view of the R channel.
  assign bus.m_axi_acp_rready = bus.mm2s_ready & busy_q;
  assign bus.mm2s_data        = bus.m_axi_acp_rdata;
  assign bus.mm2s_valid       = bus.m_axi_acp_rvalid & busy_q;
  assign bus.mm2s_last        = bus.mm2s_valid && (rcvd_q == total_q - LEN_W'(1));

endmodule

// File: tb/tb_dma_mm2s_engine.sv
// Directed bench for dma_mm2s_engine: a table of transfers against a small
// AXI read responder, plus hand sequences for reset, limits and edge starts.
module tb_dma_mm2s_engine;

  localparam int MAXO = 2;

  logic        clk;
  logic        axi_reset;
  logic        start;
  logic [31:0] src_address;
  logic [23:0] xfer_beats;
  logic        busy, done, error;
  logic [1:0]  last_resp;

  dma_mm2s_engine_if #(.DATA_W(64)) bus();

  dma_mm2s_engine #(
    .DATA_W(64), .BURST_LEN(16), .MAX_OUTSTANDING(MAXO), .LEN_W(24), .AXI_ID(3'b100)
  ) dut (
    .m_axi_acp_aclk(clk),
    .axi_reset(axi_reset),
    .start(start),
    .src_address(src_address),
    .xfer_beats(xfer_beats),
    .busy(busy),
    .done(done),
    .error(error),
    .last_resp(last_resp),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] src;
    int          beats;
    bit          toggleReady;
    int          errA;
    logic [1:0]  respA;
    int          errB;
    logic [1:0]  respB;
    int          expNumAr;
    logic [31:0] expAddr [4];
    logic [3:0]  expLen [4];
    bit          expError;
    logic [1:0]  expLastResp;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  vec_t   vecs[5];
  burst_t burstQ[$];

  int compared = 0;
  int mismatched = 0;

  // Knobs for the responder and per-transfer tallies it keeps.
  bit          arReadyEn = 1'b1;
  bit          toggleReady = 1'b0;
  bit          readyPhase = 1'b0;
  int          rBudget = -1;
  int          errA = -1, errB = -1;
  logic [1:0]  respA = 2'b00, respB = 2'b00;
  logic [31:0] expBase = '0;
  int          cyc = 0;
  int          curBeat = 0;
  int          arCount, beatsSeen, dataErrs, lastIdx, lastCount, doneCount;
  int          doneCycle, lastBeatCycle, startCycle, streamErrs, arStableErrs;
  int          outst, peakOut, rlastCount;
  logic [31:0] arAddrLog [8];
  logic [3:0]  arLenLog [8];
  bit          arPendPrev = 1'b0;
  logic [31:0] prevArAddr = '0;
  logic [3:0]  prevArLen = '0;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  task automatic clearTallies();
    arCount = 0; beatsSeen = 0; dataErrs = 0; lastIdx = -1; lastCount = 0;
    doneCount = 0; doneCycle = -1; lastBeatCycle = -100; startCycle = -1;
    streamErrs = 0; arStableErrs = 0; outst = 0; peakOut = 0; rlastCount = 0;
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Responder: drives AR ready / R beats on the falling edge, then observes
  // the settled handshakes a few ns later, well before the next rising edge.
  always begin
    logic [31:0] beatAddr;
    @(negedge clk);
    cyc++;
    bus.m_axi_acp_arready = arReadyEn;
    readyPhase = ~readyPhase;
    bus.mm2s_ready = toggleReady ? readyPhase : 1'b1;
    if (!axi_reset && burstQ.size() > 0 && (rBudget < 0 || rlastCount < rBudget)) begin
      beatAddr = burstQ[0].addr + 32'(curBeat * 8);
      bus.m_axi_acp_rvalid = 1'b1;
      bus.m_axi_acp_rdata  = pat(beatAddr);
      bus.m_axi_acp_rlast  = (curBeat == burstQ[0].len);
      bus.m_axi_acp_rresp  = (beatsSeen == errA) ? respA : (beatsSeen == errB) ? respB : 2'b00;
    end else begin
      bus.m_axi_acp_rvalid = 1'b0;
      bus.m_axi_acp_rdata  = '0;
      bus.m_axi_acp_rlast  = 1'b0;
      bus.m_axi_acp_rresp  = 2'b00;
    end
    #3;
    if (axi_reset) begin
      burstQ.delete();
      curBeat = 0;
      arPendPrev = 1'b0;
    end else begin
      if (arPendPrev && (!bus.m_axi_acp_arvalid || bus.m_axi_acp_araddr !== prevArAddr ||
                         bus.m_axi_acp_arlen !== prevArLen))
        arStableErrs++;
      arPendPrev = bus.m_axi_acp_arvalid && !bus.m_axi_acp_arready;
      prevArAddr = bus.m_axi_acp_araddr;
      prevArLen  = bus.m_axi_acp_arlen;
      if (start && !busy && !done) startCycle = cyc;
      if (done) begin
        doneCount++;
        doneCycle = cyc;
      end
      if (busy && (bus.m_axi_acp_rready !== bus.mm2s_ready)) streamErrs++;
      if (bus.mm2s_valid !== (bus.m_axi_acp_rvalid && busy)) streamErrs++;
      if (bus.m_axi_acp_arvalid && bus.m_axi_acp_arready) begin
        if (arCount < 8) begin
          arAddrLog[arCount] = bus.m_axi_acp_araddr;
          arLenLog[arCount]  = bus.m_axi_acp_arlen;
        end
        arCount++;
        burstQ.push_back('{addr: bus.m_axi_acp_araddr, len: int'(bus.m_axi_acp_arlen)});
        outst++;
        if (outst > peakOut) peakOut = outst;
      end
      if (bus.m_axi_acp_rvalid && bus.m_axi_acp_rready) begin
        if (bus.mm2s_data !== pat(expBase + 32'(beatsSeen * 8))) dataErrs++;
        if (bus.mm2s_last) begin
          lastIdx = beatsSeen;
          lastCount++;
        end
        if (bus.m_axi_acp_rlast) begin
          void'(burstQ.pop_front());
          curBeat = 0;
          outst--;
          rlastCount++;
        end else begin
          curBeat++;
        end
        beatsSeen++;
        lastBeatCycle = cyc;
      end
    end
  end

  task automatic setVec(input int i, input logic [31:0] src, input int beats, input bit tog,
                        input int eA, input logic [1:0] rA, input int eB, input logic [1:0] rB,
                        input int nAr, input logic [31:0] a0, input logic [3:0] l0,
                        input logic [31:0] a1, input logic [3:0] l1,
                        input logic [31:0] a2, input logic [3:0] l2,
                        input logic [31:0] a3, input logic [3:0] l3,
                        input bit expErr, input logic [1:0] expResp);
    vecs[i].src = src; vecs[i].beats = beats; vecs[i].toggleReady = tog;
    vecs[i].errA = eA; vecs[i].respA = rA; vecs[i].errB = eB; vecs[i].respB = rB;
    vecs[i].expNumAr = nAr;
    vecs[i].expAddr[0] = a0; vecs[i].expLen[0] = l0;
    vecs[i].expAddr[1] = a1; vecs[i].expLen[1] = l1;
    vecs[i].expAddr[2] = a2; vecs[i].expLen[2] = l2;
    vecs[i].expAddr[3] = a3; vecs[i].expLen[3] = l3;
    vecs[i].expError = expErr; vecs[i].expLastResp = expResp;
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (doneCount == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    clearTallies();
    toggleReady = v.toggleReady;
    errA = v.errA; respA = v.respA; errB = v.errB; respB = v.respB;
    expBase = v.src & ~32'd7;
    rBudget = -1;
    arReadyEn = 1'b1;
    src_address = v.src;
    xfer_beats = 24'(v.beats);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(2000);
  endtask

  task automatic checkOutput(input vec_t v);
    checkVal("done_pulses", 64'(doneCount), 64'(1));
    checkVal("ar_count", 64'(arCount), 64'(v.expNumAr));
    for (int i = 0; i < v.expNumAr && i < 4; i++) begin
      checkVal($sformatf("ar%0d_addr", i), 64'(arAddrLog[i]), 64'(v.expAddr[i]));
      checkVal($sformatf("ar%0d_len", i), 64'(arLenLog[i]), 64'(v.expLen[i]));
    end
    checkVal("beats", 64'(beatsSeen), 64'(v.beats));
    checkVal("data_errs", 64'(dataErrs), 64'(0));
    checkVal("last_index", 64'(lastIdx), 64'(v.beats - 1));
    checkVal("last_count", 64'(lastCount), 64'(1));
    checkVal("done_latency", 64'(doneCycle - lastBeatCycle), 64'(1));
    checkVal("stream_errs", 64'(streamErrs), 64'(0));
    checkVal("ar_stable_errs", 64'(arStableErrs), 64'(0));
    checkVal("peak_outstanding_ok", 64'(peakOut <= MAXO), 64'(1));
    checkVal("error", 64'(error), 64'(v.expError));
    checkVal("last_resp", 64'(last_resp), 64'(v.expLastResp));
    checkVal("busy_after", 64'(busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    axi_reset = 1'b1;
    start = 1'b0;
    src_address = '0;
    xfer_beats = '0;
    bus.m_axi_acp_arready = 1'b1;
    bus.m_axi_acp_rvalid = 1'b0;
    bus.m_axi_acp_rdata = '0;
    bus.m_axi_acp_rlast = 1'b0;
    bus.m_axi_acp_rresp = 2'b00;
    bus.mm2s_ready = 1'b1;
    clearTallies();

    repeat (3) @(negedge clk);
    #1;
    checkVal("rst_busy", 64'(busy), 64'(0));
    checkVal("rst_done", 64'(done), 64'(0));
    checkVal("rst_error", 64'(error), 64'(0));
    checkVal("rst_last_resp", 64'(last_resp), 64'(0));
    checkVal("rst_arvalid", 64'(bus.m_axi_acp_arvalid), 64'(0));
    checkVal("rst_araddr", 64'(bus.m_axi_acp_araddr), 64'(0));
    checkVal("rst_arlen", 64'(bus.m_axi_acp_arlen), 64'(0));
    checkVal("const_arid", 64'(bus.m_axi_acp_arid), 64'(4));
    checkVal("const_arsize", 64'(bus.m_axi_acp_arsize), 64'(3));
    checkVal("const_arburst", 64'(bus.m_axi_acp_arburst), 64'(1));
    @(negedge clk);
    axi_reset = 1'b0;
    repeat (2) @(negedge clk);

    setVec(0, 32'h1000_0000, 64, 1'b0, -1, 2'b00, -1, 2'b00, 4,
           32'h1000_0000, 4'd15, 32'h1000_0080, 4'd15,
           32'h1000_0100, 4'd15, 32'h1000_0180, 4'd15, 1'b0, 2'b00);
    setVec(1, 32'h0000_0FC0, 20, 1'b0, -1, 2'b00, -1, 2'b00, 2,
           32'h0000_0FC0, 4'd7, 32'h0000_1000, 4'd11, '0, '0, '0, '0, 1'b0, 2'b00);
    setVec(2, 32'h2000_0004, 32, 1'b1, 5, 2'b10, -1, 2'b00, 2,
           32'h2000_0000, 4'd15, 32'h2000_0080, 4'd15, '0, '0, '0, '0, 1'b1, 2'b10);
    setVec(3, 32'h0000_3FF8, 3, 1'b0, -1, 2'b00, -1, 2'b00, 2,
           32'h0000_3FF8, 4'd0, 32'h0000_4000, 4'd1, '0, '0, '0, '0, 1'b0, 2'b00);
    setVec(4, 32'h0000_0100, 17, 1'b1, 2, 2'b11, 10, 2'b10, 2,
           32'h0000_0100, 4'd15, 32'h0000_0180, 4'd0, '0, '0, '0, '0, 1'b1, 2'b11);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d: src=0x%08h beats=%0d", i, vecs[i].src, vecs[i].beats);
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    $display("[TB] zero-length start");
    @(negedge clk);
    clearTallies();
    toggleReady = 1'b0; errA = -1; errB = -1;
    src_address = 32'h0000_8000;
    xfer_beats = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkVal("zero_done_pulses", 64'(doneCount), 64'(1));
    checkVal("zero_done_latency", 64'(doneCycle - startCycle), 64'(1));
    checkVal("zero_ar_count", 64'(arCount), 64'(0));
    checkVal("zero_busy_after", 64'(busy), 64'(0));

    $display("[TB] outstanding limit and ignored start");
    @(negedge clk);
    clearTallies();
    rBudget = 0;
    expBase = 32'h0000_0000;
    src_address = 32'h0000_0000;
    xfer_beats = 24'd64;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checkVal("hold_ar_count", 64'(arCount), 64'(2));
    checkVal("hold_arvalid", 64'(bus.m_axi_acp_arvalid), 64'(0));
    @(negedge clk);
    src_address = 32'h0000_9000;
    xfer_beats = 24'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rBudget = 1;
    repeat (40) @(negedge clk);
    checkVal("release_ar_count", 64'(arCount), 64'(3));
    checkVal("release_rlasts", 64'(rlastCount), 64'(1));
    checkVal("release_ar3_addr", 64'(arAddrLog[2]), 64'(32'h0000_0100));
    rBudget = -1;
    waitDone(2000);
    checkVal("limit_done_pulses", 64'(doneCount), 64'(1));
    checkVal("limit_beats", 64'(beatsSeen), 64'(64));
    checkVal("limit_ar_count", 64'(arCount), 64'(4));
    checkVal("limit_last_index", 64'(lastIdx), 64'(63));
    checkVal("limit_data_errs", 64'(dataErrs), 64'(0));
    checkVal("limit_peak_outstanding", 64'(peakOut), 64'(2));

    $display("[TB] reset while an AR is pending");
    @(negedge clk);
    clearTallies();
    arReadyEn = 1'b0;
    src_address = 32'h0000_0100;
    xfer_beats = 24'd16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 10 && !bus.m_axi_acp_arvalid; n++) @(negedge clk);
    checkVal("pre_reset_arvalid", 64'(bus.m_axi_acp_arvalid), 64'(1));
    @(negedge clk);
    #1;
    axi_reset = 1'b1;
    #1;
    checkVal("async_rst_arvalid", 64'(bus.m_axi_acp_arvalid), 64'(0));
    checkVal("async_rst_busy", 64'(busy), 64'(0));
    checkVal("async_rst_done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    axi_reset = 1'b0;
    arReadyEn = 1'b1;
    applyStimulus(vecs[3]);
    checkOutput(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
